// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_arb_pkg
//  Purpose  : Shared types, default constants and the round-robin search
//             helper for the FIFO write-side arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int c_N_REQ_DEF     = 4;
    localparam int c_DATA_W_DEF    = 8;
    localparam int c_MAX_BURST_DEF = 16;
    // Widest requester vector the search helper understands
    localparam int c_RR_MAX        = 8;

    // Returns the first asserted index found when scanning last_idx+1,
    // last_idx+2, ... modulo n. Returns 0 when nothing is valid.
    function automatic int next_rr(input logic [c_RR_MAX-1:0] valid,
                                   input int                  last_idx,
                                   input int                  n);
        int win;
        int idx;
        logic found;
        win   = 0;
        idx   = 0;
        found = 1'b0;
        for (int i = 1; i <= c_RR_MAX; i++) begin
            idx = (last_idx + i) % n;
            if (!found && (i <= n) && valid[idx[2:0]]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick
//  Purpose  : Combinational round-robin winner search starting just after
//             the most recently served index.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = c_N_REQ_DEF
) (
    input  logic [N_REQ-1:0]         valid,
    input  logic [$clog2(N_REQ)-1:0] last_idx,
    output logic                     any_valid,
    output logic [$clog2(N_REQ)-1:0] pick
);

    localparam int IDX_W = $clog2(N_REQ);

    assign any_valid = |valid;
    assign pick      = IDX_W'(next_rr(c_RR_MAX'(valid), int'(last_idx), N_REQ));

endmodule
`default_nettype wire

// File: rtl/fifo_wr_arb.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_wr_arb
//  Purpose  : Round-robin arbiter sharing one FIFO write port among several
//             valid/ready/last producers; a grant lasts for a whole packet,
//             capped at MAX_BURST words.
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arb
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ     = c_N_REQ_DEF,
    parameter int DATA_W    = c_DATA_W_DEF,
    parameter int MAX_BURST = c_MAX_BURST_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    input  logic [N_REQ-1:0]          req_last,
    output logic [N_REQ-1:0]          req_ready,
    input  logic                      fifo_full,
    output logic                      fifo_wr,
    output logic [DATA_W-1:0]         fifo_data,
    output logic [N_REQ-1:0]          grant,
    output logic                      busy,
    output logic [15:0]               wr_count
);

    localparam int IDX_W  = $clog2(N_REQ);
    localparam int BEAT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [BEAT_W-1:0] c_BEAT_LAST = BEAT_W'(MAX_BURST - 1);
    localparam logic [IDX_W-1:0]  c_LAST_RST  = IDX_W'(N_REQ - 1);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic [IDX_W-1:0]  r_gnt_idx;
    logic [IDX_W-1:0]  w_gnt_nxt;
    logic [IDX_W-1:0]  r_last_idx;
    logic [IDX_W-1:0]  w_last_nxt;
    logic [BEAT_W-1:0] r_beat;
    logic [BEAT_W-1:0] w_beat_nxt;
    logic [15:0]       r_wr_count;
    logic              w_any;
    logic [IDX_W-1:0]  w_pick;
    logic              w_accept;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .valid     (req_valid),
        .last_idx  (r_last_idx),
        .any_valid (w_any),
        .pick      (w_pick)
    );

    assign wr_count = r_wr_count;

    // State, grant bookkeeping and the write counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_gnt_idx  <= '0;
            r_last_idx <= c_LAST_RST;
            r_beat     <= '0;
            r_wr_count <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt_idx  <= w_gnt_nxt;
            r_last_idx <= w_last_nxt;
            r_beat     <= w_beat_nxt;
            if (w_accept) begin
                r_wr_count <= r_wr_count + 16'd1;
            end
        end
    end

    // Next-state and handshake outputs; handshakes are held off while rst is
    // asserted so an interrupted burst never writes in the reset cycle
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt_idx;
        w_last_nxt  = r_last_idx;
        w_beat_nxt  = r_beat;
        w_accept    = 1'b0;
        req_ready   = '0;
        grant       = '0;
        busy        = 1'b0;
        fifo_data   = req_data[int'(r_gnt_idx)*DATA_W +: DATA_W];

        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_gnt_nxt   = w_pick;
                    w_state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (rst) begin
                    busy                 = 1'b1;
                    grant[r_gnt_idx]     = 1'b1;
                    req_ready[r_gnt_idx] = ~fifo_full;
                    w_accept             = req_valid[r_gnt_idx] & ~fifo_full;
                end
                if (w_accept) begin
                    if (req_last[r_gnt_idx] || (r_beat == c_BEAT_LAST)) begin
                        w_last_nxt  = r_gnt_idx;
                        w_beat_nxt  = '0;
                        w_state_nxt = IDLE;
                    end else begin
                        w_beat_nxt  = r_beat + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        fifo_wr = w_accept;
    end

endmodule
`default_nettype wire
